nn_result_tx: RTL and testbench
===============================

Name: nn_result_tx

Overview:
- Transmit side of the NN accelerator's host link; the NN core's output layer hands it a completed score vector.
- Captures NUM_OUT signed 8-bit class scores in one handshake.
- Computes the argmax class index on-chip, then serialises the frame over a UART 8N1 line: header, scores, argmax, checksum.
- Sits between the NN core's output stage and the board TX pin; the host-side receiver parses the same frame.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2 and CLKS_PER_BIT*10 > NUM_OUT.
- NUM_OUT, 10, number of output scores per frame, 1..255.
- HEADER, 8'hA5, frame sync byte.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- res_valid  input  1  score vector valid.
- res_ready  output  1  block can accept a vector.
- res_data  input  NUM_OUT*8  scores; score i = res_data[8i+7:8i], two's complement.
- tx  output  1  UART serial line, idle high.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset values (async, on rst_n low): tx=1, busy=0, res_ready=1, frame_done=0, FSM=IDLE, all counters 0. Reset mid-frame aborts immediately; tx returns high with no partial stop bit. After release, the next frame starts clean.
- Handshake and capture:
  - res_ready = ~busy.
  - A transfer occurs on a rising edge with res_valid & res_ready.
  - res_data is registered on that edge and busy rises on the same edge.
  - res_valid while busy is ignored; no queueing.
- Frame byte order: HEADER, score0..score(NUM_OUT-1), argmax, checksum. Total NUM_OUT+3 bytes.
- Checksum: XOR of all score bytes and the argmax byte; HEADER is excluded.
- Argmax:
  - Computed sequentially, one compare per clock, starting the cycle after capture; it completes during HEADER transmission.
  - Signed compare; ties resolve to the lowest index.
  - Emitted as an 8-bit unsigned index.
- Byte framing:
  - Each byte is one start bit (0), 8 data bits LSB first, one stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - No idle gap between bytes of a frame.
- Timing:
  - The start bit of HEADER appears on tx the first cycle after the capture edge.
  - Frame length is (NUM_OUT+3)*10*CLKS_PER_BIT cycles.
- FSM states:
  - IDLE → START on handshake.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → STOP after 8 bits.
  - STOP → START if byte_idx < NUM_OUT+2, incrementing byte_idx; otherwise STOP → DONE.
  - DONE → IDLE in one cycle.
- Frame end:
  - DONE lasts one cycle: frame_done=1, tx=1, busy still 1.
  - On the next cycle busy=0 and res_ready=1.
  - Earliest next capture is the cycle after DONE.
- Counters:
  - Bit-timing counter: ceil(log2(CLKS_PER_BIT)) bits, wraps to 0 at CLKS_PER_BIT-1.
  - bit_idx: 3 bits.
  - byte_idx: 9 bits.
  - No arithmetic overflow is possible on scores; they are only compared and XORed.

Test Plan (CLKS_PER_BIT=4, NUM_OUT=4 unless stated):
- Reset / idle:
  - Stimulus: assert rst_n=0 with clk stopped, then release and apply no stimulus.
  - Required: tx=1, busy=0, res_ready=1, frame_done=0; tx stays 1 for 100 cycles.
- Basic frame:
  - Stimulus: res_data scores {05,FE,7F,10} for i=0..3.
  - Required: tx decodes A5,05,FE,7F,10,02,96. Start bit begins 1 cycle after capture. frame_done pulses exactly 280 cycles after the first start-bit cycle. busy falls the cycle after that pulse.
- Ties / all negative:
  - Stimulus: scores {80,80,80,80}.
  - Required: argmax=00, checksum=00, frame A5,80,80,80,80,00,00.
- Ignored valid:
  - Stimulus: hold res_valid=1 through a whole frame, changing res_data mid-frame.
  - Required: the transmitted frame matches the captured data. The second vector is accepted only on the cycle after frame_done, giving back-to-back frames with no lost bits.
- Reset mid-frame:
  - Stimulus: drop rst_n during the DATA bits of score1.
  - Required: tx=1 within the same cycle and busy=0. After release, a new vector {01,02,03,04} yields A5,01,02,03,04,03,07.
- Parameter corner:
  - Stimulus: NUM_OUT=1, CLKS_PER_BIT=2, score {3C}.
  - Required: frame A5,3C,00,3C; total length 80 cycles.

Source files
------------

// File: rtl/nn_result_tx.sv
// Result transmitter: captures a vector of signed 8-bit class scores and sends it
// over UART 8N1 as HEADER, scores, argmax index and an XOR checksum.
module nn_result_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          NUM_OUT      = 10,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   res_valid,
    output logic                   res_ready,
    input  logic [NUM_OUT*8-1:0]   res_data,
    output logic                   tx,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [8:0]     NUM_OUT_9 = 9'(NUM_OUT);
    localparam logic [8:0]     LAST_BYTE = 9'(NUM_OUT + 2);
    localparam logic [8:0]     ARGMAX_BYTE = 9'(NUM_OUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [8:0]             byte_idx_q, byte_idx_d;
    logic [NUM_OUT*8-1:0]   data_q, data_d;
    logic [7:0]             max_val_q, max_val_d;
    logic [7:0]             max_idx_q, max_idx_d;
    logic [8:0]             cmp_idx_q, cmp_idx_d;
    logic [7:0]             xor_q, xor_d;

    logic                   capture;
    logic                   bit_done;
    logic [7:0]             cmp_score;
    logic [7:0]             tx_score;
    logic [7:0]             cur_byte;
    logic [7:0]             score [NUM_OUT];

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_unpack
            assign score[gi] = data_q[8*gi +: 8];
        end
    endgenerate

    assign busy       = (state_q != S_IDLE);
    assign res_ready  = ~busy;
    assign frame_done = (state_q == S_DONE);
    assign capture    = (state_q == S_IDLE) && res_valid;
    assign bit_done   = (cnt_q == CNT_MAX);

    // Score selectors: one for the running argmax, one for the byte being sent.
    always_comb begin
        cmp_score = 8'h00;
        tx_score  = 8'h00;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (cmp_idx_q == 9'(k)) begin
                cmp_score = score[k];
            end
            if (byte_idx_q == 9'(k + 1)) begin
                tx_score = score[k];
            end
        end
    end

    // Argmax and checksum run one score per clock right after capture; both
    // settle long before their bytes are reached because a whole byte time
    // (10*CLKS_PER_BIT cycles) exceeds NUM_OUT.
    always_comb begin
        data_d    = data_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        cmp_idx_d = cmp_idx_q;
        xor_d     = xor_q;
        if (capture) begin
            data_d    = res_data;
            max_val_d = res_data[7:0];
            max_idx_d = 8'd0;
            xor_d     = res_data[7:0];
            cmp_idx_d = 9'd1;
        end else if (busy && (cmp_idx_q < NUM_OUT_9)) begin
            if ($signed(cmp_score) > $signed(max_val_q)) begin
                max_val_d = cmp_score;
                max_idx_d = cmp_idx_q[7:0];
            end
            xor_d     = xor_q ^ cmp_score;
            cmp_idx_d = cmp_idx_q + 9'd1;
        end
    end

    always_comb begin
        if (byte_idx_q == 9'd0) begin
            cur_byte = HEADER;
        end else if (byte_idx_q <= NUM_OUT_9) begin
            cur_byte = tx_score;
        end else if (byte_idx_q == ARGMAX_BYTE) begin
            cur_byte = max_idx_q;
        end else begin
            cur_byte = xor_q ^ max_idx_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        case (state_q)
            S_IDLE: begin
                if (res_valid) begin
                    state_d    = S_START;
                    cnt_d      = '0;
                    bit_idx_d  = 3'd0;
                    byte_idx_d = 9'd0;
                end
            end
            S_START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        state_d   = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (byte_idx_q < LAST_BYTE) begin
                        byte_idx_d = byte_idx_q + 9'd1;
                        state_d    = S_START;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                byte_idx_d = 9'd0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level is decoded straight from state so an async reset idles it at once.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            S_START: tx = 1'b0;
            S_DATA:  tx = cur_byte[bit_idx_q];
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 9'd0;
            data_q     <= '0;
            max_val_q  <= 8'h00;
            max_idx_q  <= 8'h00;
            cmp_idx_q  <= 9'd0;
            xor_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            data_q     <= data_d;
            max_val_q  <= max_val_d;
            max_idx_q  <= max_idx_d;
            cmp_idx_q  <= cmp_idx_d;
            xor_q      <= xor_d;
        end
    end

endmodule

// File: tb/tb_nn_result_tx.sv
// Bench for nn_result_tx: two instances (4 scores @ 4 clk/bit, 1 score @ 2 clk/bit),
// UART decoders feeding a scoreboard of expected frame bytes.
module tb_nn_result_tx;

    localparam int         CPB0 = 4;
    localparam int         N0   = 4;
    localparam int         CPB1 = 2;
    localparam int         N1   = 1;
    localparam logic [7:0] HDR  = 8'hA5;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst_n = 1'b1;

    logic        res_valid0 = 1'b0;
    logic        res_ready0;
    logic [31:0] res_data0 = '0;
    logic        tx0, busy0, frame_done0;

    logic        res_valid1 = 1'b0;
    logic        res_ready1;
    logic [7:0]  res_data1 = '0;
    logic        tx1, busy1, frame_done1;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  exp_q0[$];
    logic [7:0]  exp_q1[$];

    nn_result_tx #(.CLKS_PER_BIT(CPB0), .NUM_OUT(N0), .HEADER(HDR)) dut0 (
        .clk(clk), .rst_n(rst_n), .res_valid(res_valid0), .res_ready(res_ready0),
        .res_data(res_data0), .tx(tx0), .busy(busy0), .frame_done(frame_done0)
    );

    nn_result_tx #(.CLKS_PER_BIT(CPB1), .NUM_OUT(N1), .HEADER(HDR)) dut1 (
        .clk(clk), .rst_n(rst_n), .res_valid(res_valid1), .res_ready(res_ready1),
        .res_data(res_data1), .tx(tx1), .busy(busy1), .frame_done(frame_done1)
    );

    initial begin
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input int w);
        return (w == 0) ? tx0 : tx1;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 0) ? busy0 : busy1;
    endfunction
    function automatic logic get_ready(input int w);
        return (w == 0) ? res_ready0 : res_ready1;
    endfunction
    function automatic logic get_done(input int w);
        return (w == 0) ? frame_done0 : frame_done1;
    endfunction

    // Reference frame: header, scores, signed argmax (first max wins), XOR checksum.
    task automatic push_exp(input int w, input logic [31:0] d);
        int         n;
        logic [7:0] s, best, am, chk;
        n    = (w == 0) ? N0 : N1;
        best = d[7:0];
        am   = 8'd0;
        chk  = 8'd0;
        if (w == 0) exp_q0.push_back(HDR); else exp_q1.push_back(HDR);
        for (int k = 0; k < n; k++) begin
            s   = d[8*k +: 8];
            chk = chk ^ s;
            if ($signed(s) > $signed(best)) begin
                best = s;
                am   = 8'(k);
            end
            if (w == 0) exp_q0.push_back(s); else exp_q1.push_back(s);
        end
        chk = chk ^ am;
        if (w == 0) begin
            exp_q0.push_back(am);
            exp_q0.push_back(chk);
        end else begin
            exp_q1.push_back(am);
            exp_q1.push_back(chk);
        end
    endtask

    // UART decoders: sample mid-bit on the falling edge, abort on reset.
    bit         m_act [2];
    int         m_cyc [2];
    logic [7:0] m_sh  [2];
    logic       m_tx;
    int         m_cpb;
    int         m_h;
    logic [7:0] m_exp;

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                m_tx  = get_tx(i);
                m_cpb = (i == 0) ? CPB0 : CPB1;
                m_h   = m_cpb / 2;
                if (!rst_n) begin
                    m_act[i] = 1'b0;
                end else if (!m_act[i]) begin
                    if (m_tx == 1'b0) begin
                        m_act[i] = 1'b1;
                        m_cyc[i] = 0;
                    end
                end else begin
                    m_cyc[i]++;
                    if (m_cyc[i] == m_h) begin
                        check_eq("start_bit", 32'(m_tx), 32'd0);
                    end else if (m_cyc[i] > m_h && m_cyc[i] < m_h + 9*m_cpb
                                 && ((m_cyc[i] - m_h) % m_cpb) == 0) begin
                        m_sh[i][(m_cyc[i] - m_h)/m_cpb - 1] = m_tx;
                    end else if (m_cyc[i] == m_h + 9*m_cpb) begin
                        check_eq("stop_bit", 32'(m_tx), 32'd1);
                        m_act[i] = 1'b0;
                        if (i == 0) begin
                            check_eq("byte_expected", 32'(exp_q0.size() != 0), 32'd1);
                            m_exp = (exp_q0.size() != 0) ? exp_q0.pop_front() : 8'hxx;
                        end else begin
                            check_eq("byte_expected", 32'(exp_q1.size() != 0), 32'd1);
                            m_exp = (exp_q1.size() != 0) ? exp_q1.pop_front() : 8'hxx;
                        end
                        $display("dut%0d rx byte %02h (expected %02h)", i, m_sh[i], m_exp);
                        check_eq("rx_byte", 32'(m_sh[i]), 32'(m_exp));
                    end
                end
            end
        end
    end

    task automatic wait_ready(input int w);
        int c = 0;
        @(negedge clk);
        while (!get_ready(w) && c < 10000) begin
            @(negedge clk);
            c++;
        end
        check_eq("ready_timeout", 32'(get_ready(w)), 32'd1);
    endtask

    task automatic drive(input int w, input logic [31:0] d, input logic v);
        if (w == 0) begin
            res_valid0 = v;
            res_data0  = d;
        end else begin
            res_valid1 = v;
            res_data1  = d[7:0];
        end
    endtask

    // Called on the negedge of the first start-bit cycle; waits for frame_done
    // and then checks that the block is free again on the following cycle.
    task automatic wait_frame_end(input int w, input int exp_len);
        int c = 0;
        while (c < 10000) begin
            @(negedge clk);
            c++;
            if (get_done(w)) break;
        end
        check_eq("frame_len", 32'(c), 32'(exp_len));
        check_eq("done_busy", 32'(get_busy(w)), 32'd1);
        @(negedge clk);
        check_eq("idle_busy", 32'(get_busy(w)), 32'd0);
        check_eq("idle_ready", 32'(get_ready(w)), 32'd1);
        check_eq("idle_done", 32'(get_done(w)), 32'd0);
    endtask

    task automatic start_frame(input int w, input logic [31:0] d);
        push_exp(w, d);
        wait_ready(w);
        drive(w, d, 1'b1);
        @(negedge clk);
        drive(w, d, 1'b0);
        check_eq("start_latency", 32'(get_tx(w)), 32'd0);
        check_eq("busy_rise", 32'(get_busy(w)), 32'd1);
    endtask

    task automatic do_frame(input int w, input logic [31:0] d);
        start_frame(w, d);
        wait_frame_end(w, (w == 0) ? (N0 + 3)*10*CPB0 : (N1 + 3)*10*CPB1);
    endtask

    initial begin
        int tx_low;
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_tx", 32'(tx0), 32'd1);
        check_eq("rst_busy", 32'(busy0), 32'd0);
        check_eq("rst_ready", 32'(res_ready0), 32'd1);
        check_eq("rst_done", 32'(frame_done0), 32'd0);
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tx_low = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || tx1 !== 1'b1) tx_low++;
        end
        check_eq("idle_tx_low_cycles", 32'(tx_low), 32'd0);

        // basic frame: A5,05,FE,7F,10,02,96
        do_frame(0, 32'h107FFE05);
        // ties among negatives: A5,80,80,80,80,00,00
        do_frame(0, 32'h80808080);

        // valid held through a frame; data changes mid-frame must not leak in
        start_frame(0, 32'h9C3B3B01);
        drive(0, 32'h9C3B3B01, 1'b1);
        repeat (100) @(negedge clk);
        drive(0, 32'hF0332211, 1'b1);
        push_exp(0, 32'hF0332211);
        wait_frame_end(0, (N0 + 3)*10*CPB0 - 100);
        @(negedge clk);
        drive(0, 32'hF0332211, 1'b0);
        check_eq("b2b_start", 32'(tx0), 32'd0);
        check_eq("b2b_busy", 32'(busy0), 32'd1);
        wait_frame_end(0, (N0 + 3)*10*CPB0);

        // reset during score1 data bits
        start_frame(0, 32'hDDCCBBAA);
        repeat (95) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_tx", 32'(tx0), 32'd1);
        check_eq("abort_busy", 32'(busy0), 32'd0);
        check_eq("abort_ready", 32'(res_ready0), 32'd1);
        exp_q0.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // A5,01,02,03,04,03,07
        do_frame(0, 32'h04030201);

        // single-score instance: A5,3C,00,3C in 80 cycles
        do_frame(1, 32'h0000003C);

        repeat (20) @(negedge clk);
        check_eq("q0_drained", 32'(exp_q0.size()), 32'd0);
        check_eq("q1_drained", 32'(exp_q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
